// File: rtl/count_control_pkg.sv
// count_control_pkg
//   Shared definitions for the run/pause control stage of the Johnson-counter
//   display path: FSM state encoding and the electrical level of a pressed
//   board button.
package count_control_pkg;

   typedef enum logic {
      PAUSED  = 1'b0,
      RUNNING = 1'b1
   } state_t;

   // Board buttons pull low when pressed.
   localparam logic BTN_PRESSED  = 1'b0;
   localparam logic BTN_RELEASED = 1'b1;

   // True when a newly accepted debounced level means "button went down".
   function automatic logic is_press_level(input logic new_level);
      return new_level == BTN_PRESSED;
   endfunction

endpackage

// File: rtl/count_control_debouncer.sv
// debouncer
//   Synchronises one raw asynchronous push-button and accepts a new level
//   only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
//   Emits a registered one-cycle pulse when the accepted level becomes
//   "pressed"; a release is accepted silently.
//
//   Ports:
//     clock    in   system clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     raw      in   raw button level (active-low, asynchronous)
//     level    out  debounced (stable) button level
//     press    out  one-cycle pulse on an accepted released->pressed change
module debouncer
   import count_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic             stable;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= BTN_RELEASED;
         sync_p1 <= BTN_RELEASED;
         cnt     <= '0;
         stable  <= BTN_RELEASED;
         press   <= 1'b0;
      end else begin
         // stage p0/p1: two-flop synchroniser
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // debounce window: any sample agreeing with the stable level
         // (a bounce) restarts the count from zero
         press   <= 1'b0;
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync_p1;
            cnt    <= '0;
            press  <= is_press_level(sync_p1);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = stable;

endmodule

// File: rtl/count_control.sv
// count_control
//   Upstream control for the Johnson-counter display path. Debounces the
//   run/pause, single-step and direction buttons, runs a PAUSED/RUNNING FSM
//   and turns the divider tick (RUNNING) or a step press (PAUSED) into a
//   registered one-cycle count-enable pulse. Also holds the count direction.
//
//   Ports:
//     clock     in   system clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     tick      in   one-cycle rate pulse from the frequency divider
//     btn_run   in   raw run/pause button, active-low
//     btn_step  in   raw single-step button, active-low
//     btn_dir   in   raw direction button, active-low
//     enable    out  registered one-cycle count-enable pulse
//     dir       out  registered direction, 0 = up, 1 = down
//     running   out  registered, 1 while RUNNING
module count_control
   import count_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tick,
   input  logic btn_run,
   input  logic btn_step,
   input  logic btn_dir,
   output logic enable,
   output logic dir,
   output logic running
);

   logic   run_press;
   logic   step_press;
   logic   dir_press;
   // Debounced levels are not needed by this stage.
   logic   unused_run_level;
   logic   unused_step_level;
   logic   unused_dir_level;

   state_t state_q;
   state_t state_d;
   logic   enable_d;

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn_run),
      .level   (unused_run_level),
      .press   (run_press)
   );

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn_step),
      .level   (unused_step_level),
      .press   (step_press)
   );

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (btn_dir),
      .level   (unused_dir_level),
      .press   (dir_press)
   );

   // The enable source is chosen from the current state, so a run press
   // landing on the same edge as a tick still lets that tick through when
   // leaving RUNNING, and suppresses it when leaving PAUSED.
   always_comb begin
      state_d  = state_q;
      enable_d = 1'b0;
      case (state_q)
         PAUSED: begin
            enable_d = step_press;
            if (run_press) state_d = RUNNING;
         end
         RUNNING: begin
            enable_d = tick;
            if (run_press) state_d = PAUSED;
         end
         default: begin
            state_d  = PAUSED;
            enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PAUSED;
         enable  <= 1'b0;
         dir     <= 1'b0;
      end else begin
         state_q <= state_d;
         enable  <= enable_d;
         dir     <= dir ^ dir_press;
      end
   end

   assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_count_control.sv
module tb_count_control;

   localparam int DEB = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic tick;
   logic btn_run;
   logic btn_step;
   logic btn_dir;
   logic enable;
   logic dir;
   logic running;

   count_control #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .tick     (tick),
      .btn_run  (btn_run),
      .btn_step (btn_step),
      .btn_dir  (btn_dir),
      .enable   (enable),
      .dir      (dir),
      .running  (running)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   edge_no;
      logic en;
      logic dr;
      logic rn;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  mon_ev;
   int   tests = 0;
   int   fails = 0;
   int   ecount = 0;
   logic prev_dir = 1'b0;
   logic prev_run = 1'b0;
   logic exp_dir = 1'b0;
   logic exp_run = 1'b0;
   int   b;

   always @(posedge clock) ecount <= ecount + 1;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, ecount);
      end
   endfunction

   // Expected events are kept ordered by the edge at which they must appear.
   task automatic expect_ev(input int e, input logic en, input logic dr, input logic rn);
      ev_t ev;
      int  idx;
      ev.edge_no = e;
      ev.en      = en;
      ev.dr      = dr;
      ev.rn      = rn;
      idx = exp_q.size();
      while (idx > 0 && exp_q[idx-1].edge_no > e) idx--;
      exp_q.insert(idx, ev);
   endtask

   // Monitor: an output event is an enable pulse or any change of dir/running.
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_dir = 1'b0;
         prev_run = 1'b0;
      end else if (enable !== 1'b0 || dir !== prev_dir || running !== prev_run) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event_edge", ecount, 32'hFFFF_FFFF);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("event_edge", ecount, mon_ev.edge_no);
            chk("event_enable", {31'd0, enable}, {31'd0, mon_ev.en});
            chk("event_dir", {31'd0, dir}, {31'd0, mon_ev.dr});
            chk("event_running", {31'd0, running}, {31'd0, mon_ev.rn});
         end
         prev_dir = dir;
         prev_run = running;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One-cycle tick, driven at a falling edge; passes through only in RUNNING.
   task automatic do_tick();
      tick = 1'b1;
      if (exp_run) expect_ev(ecount + 1, 1'b1, exp_dir, 1'b1);
      @(negedge clock);
      tick = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d edges, expected completion", ecount);
      $fatal(1, "timeout");
   end

   initial begin
      reset_n  = 1'b0;
      tick     = 1'b0;
      btn_run  = 1'b1;
      btn_step = 1'b1;
      btn_dir  = 1'b1;
      #12;
      chk("reset_enable", {31'd0, enable}, 32'd0);
      chk("reset_dir", {31'd0, dir}, 32'd0);
      chk("reset_running", {31'd0, running}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      idle(2);

      // Ticks while PAUSED are ignored.
      repeat (3) begin
         do_tick();
         idle(2);
      end
      chk("paused_running", {31'd0, running}, 32'd0);

      // Run held: RUNNING six edges after the sampling edge, ticks pass, no retoggle.
      btn_run = 1'b0;
      b = ecount + 1;
      exp_run = 1'b1;
      expect_ev(b + 6, 1'b0, exp_dir, 1'b1);
      idle(8);
      do_tick();
      idle(2);
      do_tick();
      idle(5);
      btn_run = 1'b1;
      idle(8);

      // Bounce: low 2, high 1, then low; toggle 6 edges after the final fall.
      btn_run = 1'b0;
      b = ecount + 1;
      idle(2);
      btn_run = 1'b1;
      idle(1);
      btn_run = 1'b0;
      exp_run = 1'b0;
      expect_ev(b + 9, 1'b0, exp_dir, 1'b0);
      idle(10);
      btn_run = 1'b1;
      idle(8);

      // Step press while PAUSED gives exactly one enable.
      btn_step = 1'b0;
      b = ecount + 1;
      expect_ev(b + 6, 1'b1, exp_dir, 1'b0);
      idle(10);
      btn_step = 1'b1;
      idle(8);

      // Back to RUNNING; a step press there is ignored, ticks still pass.
      btn_run = 1'b0;
      b = ecount + 1;
      exp_run = 1'b1;
      expect_ev(b + 6, 1'b0, exp_dir, 1'b1);
      idle(10);
      btn_run = 1'b1;
      idle(8);
      btn_step = 1'b0;
      idle(10);
      do_tick();
      idle(2);
      btn_step = 1'b1;
      idle(8);

      // Run press coincident with tick in RUNNING: pulse and pause on the same edge.
      btn_run = 1'b0;
      b = ecount + 1;
      idle(6);
      tick = 1'b1;
      exp_run = 1'b0;
      expect_ev(b + 6, 1'b1, exp_dir, 1'b0);
      @(negedge clock);
      tick = 1'b0;
      idle(4);
      btn_run = 1'b1;
      idle(8);

      // Run and step pressed together in PAUSED: one pulse and RUNNING.
      btn_run  = 1'b0;
      btn_step = 1'b0;
      b = ecount + 1;
      exp_run = 1'b1;
      expect_ev(b + 6, 1'b1, exp_dir, 1'b1);
      idle(10);
      btn_run  = 1'b1;
      btn_step = 1'b1;
      idle(8);

      // Direction presses toggle dir, with a release between each.
      for (int i = 0; i < 3; i++) begin
         btn_dir = 1'b0;
         b = ecount + 1;
         exp_dir = ~exp_dir;
         expect_ev(b + 6, 1'b0, exp_dir, exp_run);
         idle(10);
         btn_dir = 1'b1;
         idle(8);
      end

      // Reset mid-debounce with run held: outputs clear at once, then the
      // held button is taken as a fresh press after a full debounce.
      btn_run = 1'b0;
      idle(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midreset_enable", {31'd0, enable}, 32'd0);
      chk("midreset_dir", {31'd0, dir}, 32'd0);
      chk("midreset_running", {31'd0, running}, 32'd0);
      @(negedge clock);
      idle(2);
      reset_n = 1'b1;
      b = ecount + 1;
      exp_dir = 1'b0;
      exp_run = 1'b1;
      expect_ev(b + 6, 1'b0, 1'b0, 1'b1);
      idle(10);
      btn_run = 1'b1;
      idle(10);

      chk("pending_events", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/count_control.md
# count_control

Upstream control stage for the Johnson-counter display path. Debounces three raw board push-buttons (run/pause, single-step, direction), runs a two-state run/pause FSM, and gates the one-cycle `tick` from the frequency divider into the counter's `enable` pulse. It also outputs a registered count direction. The counter and display scanner consume `enable` and `dir` directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable clock cycles required to accept a button level (20 ms at 50 MHz); legal range ≥ 2.

Ports:
- `clock`  input  1  system clock; all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-cycle rate pulse from the frequency divider.
- `btn_run`  input  1  raw run/pause button, asynchronous, active-low (0 = pressed).
- `btn_step`  input  1  raw single-step button, asynchronous, active-low.
- `btn_dir`  input  1  raw direction button, asynchronous, active-low.
- `enable`  output  1  registered one-cycle count-enable pulse to the counter.
- `dir`  output  1  registered count direction: 0 = up, 1 = down.
- `running`  output  1  registered: 1 in RUNNING, 0 in PAUSED.

## Operation
- Reset values (asynchronous, immediate): `enable` = 0, `dir` = 0, `running` = 0 (PAUSED). Synchroniser flops and stable levels = 1 (released). Debounce counters = 0. Press pulses = 0.
- Per button:
  - 2-flop synchroniser produces `s`.
  - Debounce counter, width `$clog2(DEBOUNCE_CYCLES)`:
    - if `s` == stable: counter <= 0.
    - else if counter == DEBOUNCE_CYCLES-1: stable <= `s`, counter <= 0.
    - else: counter <= counter+1.
  - Press pulse (registered) = 1 for exactly one cycle when stable changes 1→0. A release (0→1) produces no pulse.
- FSM states: PAUSED, RUNNING.
  - PAUSED → RUNNING on run press.
  - RUNNING → PAUSED on run press.
  - No other transitions.
- `enable` next value:
  - RUNNING: `tick`.
  - PAUSED: step press.
  - Both use the current state, before any transition taken on the same edge.
- Step press while RUNNING: ignored.
- `tick` while PAUSED: ignored.
- Dir press: `dir` <= ~`dir`, in either state.
- Simultaneous run press and `tick` in RUNNING: `enable` pulses on that edge, then PAUSED. In PAUSED, the same combination gives no pulse and a move to RUNNING.
- Simultaneous run and step press in PAUSED: one `enable` pulse and a move to RUNNING.
- Reset mid-debounce or mid-pulse: everything returns to reset values. No pulse escapes. A button still held at reset release is accepted as a new press after the full debounce.

## Timing
- Raw falling edge sampled at clock edge 1:
  - synchroniser output low at edge 2;
  - counter increments from edge 3;
  - stable <= 0 at edge DEBOUNCE_CYCLES+2;
  - press pulse high in the following cycle;
  - FSM, `enable` or `dir` update at edge DEBOUNCE_CYCLES+3.
- `tick` → `enable` latency: 1 cycle. `enable` is never wider than one cycle for a one-cycle `tick`.
- Any synchronised sample equal to the stable level (a bounce) restarts the full DEBOUNCE_CYCLES window.
- A held button yields exactly one press. A new press requires release, debounce high, then debounce low again.

## Structure
- Shared package constants:
  - FSM state encoding: PAUSED = 0, RUNNING = 1.
  - Button active level: `BTN_PRESSED` = 0.
- Sub-module `debouncer`, parameter DEBOUNCE_CYCLES:
  - ports `clock`, `reset_n`, `raw`, `level`, `press`.
  - instantiated three times, once per button.
- FSM, `enable` and `dir` logic live in the top module.
- Estimated size: about 150–250 lines.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset → `enable`=0, `dir`=0, `running`=0. `tick` every 3 cycles while PAUSED → `enable` stays 0.
- `btn_run` held low from edge 1 → `running`=1 at edge 7. Thereafter each `tick` gives an `enable` pulse 1 cycle later. Holding `btn_run` gives no further toggle.
- Bounce: `btn_run` low 2 cycles, high 1, then low steady → `running` rises only 4 stable cycles after the final fall. No toggle from the glitch.
- PAUSED, `btn_step` press → exactly one `enable` pulse at edge 7. Same press in RUNNING → no extra pulse beyond `tick`-driven ones.
- `btn_dir` press twice (with release between) → `dir` 0→1→0. Each change occurs 7 edges after the respective fall.
- RUNNING, run press coincident with `tick` → one `enable` pulse, then `running`=0. `reset_n` low mid-debounce → all outputs 0 immediately. No pulse after release unless the button is re-debounced.
